// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: opcodes, ALUOp and forwarding encodings, and the control bundle carried down the pipe
package pipe_ctrl_pkg;
  localparam int OP_R_FORMAT = 0;
  localparam int OP_J        = 2;
  localparam int OP_BEQ      = 4;
  localparam int OP_ADDIU    = 9;
  localparam int OP_MADDU    = 28;
  localparam int OP_LW       = 35;
  localparam int OP_SW       = 43;
  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10} alu_op_e;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_MEMWB = 2'b01, FWD_EXMEM = 2'b10} fwd_sel_e;
  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    alu_op_e alu_op;
    logic    branch;
    logic    jump;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    mem_to_reg;
    logic    is_mul;
    logic    illegal;
  } ctrl_bundle_t;
  localparam ctrl_bundle_t CTRL_NOP = '0;
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: ID-stage inputs and per-stage control outputs; fwd_a/fwd_b exist only with PIPE_CTRL_FWD_EN
interface pipe_ctrl_if #(parameter int OPCODE_W = 6, parameter int REG_ADDR_W = 5);
  logic [OPCODE_W-1:0]   opcode_id;
  logic [REG_ADDR_W-1:0] rs_id, rt_id, rd_id;
  logic                  br_taken_ex;
  logic                  pc_write, ifid_write, ifid_flush;
  logic                  ex_alu_src, ex_branch, ex_jump, ex_mul_busy;
  logic [1:0]            ex_alu_op;
  logic                  mem_read, mem_write;
  logic                  wb_reg_write, wb_mem_to_reg;
  logic [REG_ADDR_W-1:0] wb_dst;
  logic                  illegal_op;
`ifdef PIPE_CTRL_FWD_EN
  logic [1:0]            fwd_a, fwd_b;
  modport master (
    output opcode_id, rs_id, rt_id, rd_id, br_taken_ex,
    input  pc_write, ifid_write, ifid_flush, ex_alu_src, ex_branch, ex_jump, ex_mul_busy, ex_alu_op,
           mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_dst, illegal_op, fwd_a, fwd_b
  );
  modport slave (
    input  opcode_id, rs_id, rt_id, rd_id, br_taken_ex,
    output pc_write, ifid_write, ifid_flush, ex_alu_src, ex_branch, ex_jump, ex_mul_busy, ex_alu_op,
           mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_dst, illegal_op, fwd_a, fwd_b
  );
`else
  modport master (
    output opcode_id, rs_id, rt_id, rd_id, br_taken_ex,
    input  pc_write, ifid_write, ifid_flush, ex_alu_src, ex_branch, ex_jump, ex_mul_busy, ex_alu_op,
           mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_dst, illegal_op
  );
  modport slave (
    input  opcode_id, rs_id, rt_id, rd_id, br_taken_ex,
    output pc_write, ifid_write, ifid_flush, ex_alu_src, ex_branch, ex_jump, ex_mul_busy, ex_alu_op,
           mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_dst, illegal_op
  );
`endif
endinterface

// File: rtl/pipe_ctrl_decode.sv
// ctrl_decode: combinational opcode to control bundle; unknown opcodes become a NOP flagged illegal
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output ctrl_bundle_t        ctrl_o
);
  always_comb begin
    ctrl_o = CTRL_NOP;
    case (opcode_i)
      OPCODE_W'(OP_R_FORMAT): begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.alu_op    = ALU_FUNCT;
        ctrl_o.reg_write = 1'b1;
      end
      OPCODE_W'(OP_MADDU): begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.alu_op    = ALU_FUNCT;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.is_mul    = 1'b1;
      end
      OPCODE_W'(OP_ADDIU): begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      OPCODE_W'(OP_LW): begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      OPCODE_W'(OP_SW): begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      OPCODE_W'(OP_BEQ): begin
        ctrl_o.branch = 1'b1;
        ctrl_o.alu_op = ALU_SUB;
      end
      OPCODE_W'(OP_J): ctrl_o.jump = 1'b1;
      default: ctrl_o.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: MIPS pipeline control (decode, ID/EX-EX/MEM-MEM/WB bundles, hazards, flush, MADDU hold)
// PIPE_CTRL_FWD_EN adds fwd_a/fwd_b and reduces RAW stalls to load-use only
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int OPCODE_W   = 6,
  parameter int REG_ADDR_W = 5,
  parameter int MUL_CYCLES = 4
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave ctl
);
  localparam int CNT_W = $clog2(MUL_CYCLES + 1);
  typedef logic [REG_ADDR_W-1:0] reg_t;
  ctrl_bundle_t     id_ctrl, idex_q, idex_d;
  reg_t             idex_rt_q, idex_rt_d, idex_rd_q, idex_rd_d, ex_dst, exmem_dst_q, memwb_dst_q;
  logic             exmem_mr_q, exmem_mw_q, exmem_rw_q, exmem_m2r_q, memwb_rw_q, memwb_m2r_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             id_use_rs, id_use_rt, hold, flush, stall, bubble;
`ifdef PIPE_CTRL_FWD_EN
  reg_t             idex_rs_q, idex_rs_d;
`endif

  function automatic logic hit(reg_t src, reg_t dst, logic we);
    return we && dst != '0 && src == dst;
  endfunction

  ctrl_decode #(.OPCODE_W(OPCODE_W)) u_dec (.opcode_i(ctl.opcode_id), .ctrl_o(id_ctrl));

  always_comb begin
    id_use_rs = !id_ctrl.jump;
    id_use_rt = id_ctrl.reg_dst || id_ctrl.mem_write || id_ctrl.branch;
    ex_dst    = !idex_q.reg_write ? '0 : idex_q.reg_dst ? idex_rd_q : idex_rt_q;
    hold      = cnt_q != '0;
    flush     = ctl.br_taken_ex && !hold;
`ifdef PIPE_CTRL_FWD_EN
    stall     = idex_q.mem_read &&
                ((id_use_rs && hit(ctl.rs_id, ex_dst, idex_q.reg_write)) ||
                 (id_use_rt && hit(ctl.rt_id, ex_dst, idex_q.reg_write)));
`else
    // WB needs no check: the register file writes in the first half-cycle
    stall     = (id_use_rs && (hit(ctl.rs_id, ex_dst, idex_q.reg_write) || hit(ctl.rs_id, exmem_dst_q, exmem_rw_q))) ||
                (id_use_rt && (hit(ctl.rt_id, ex_dst, idex_q.reg_write) || hit(ctl.rt_id, exmem_dst_q, exmem_rw_q)));
`endif
    bubble    = flush || stall;
    idex_d    = hold ? idex_q : bubble ? CTRL_NOP : id_ctrl;
    idex_rt_d = hold ? idex_rt_q : bubble ? '0 : ctl.rt_id;
    idex_rd_d = hold ? idex_rd_q : bubble ? '0 : ctl.rd_id;
`ifdef PIPE_CTRL_FWD_EN
    idex_rs_d = hold ? idex_rs_q : bubble ? '0 : ctl.rs_id;
`endif
    cnt_d     = hold ? cnt_q - CNT_W'(1) : idex_d.is_mul ? CNT_W'(MUL_CYCLES - 1) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q      <= CTRL_NOP;
      idex_rt_q   <= '0;
      idex_rd_q   <= '0;
      cnt_q       <= '0;
      exmem_mr_q  <= 1'b0;
      exmem_mw_q  <= 1'b0;
      exmem_rw_q  <= 1'b0;
      exmem_m2r_q <= 1'b0;
      exmem_dst_q <= '0;
      memwb_rw_q  <= 1'b0;
      memwb_m2r_q <= 1'b0;
      memwb_dst_q <= '0;
    end else begin
      idex_q      <= idex_d;
      idex_rt_q   <= idex_rt_d;
      idex_rd_q   <= idex_rd_d;
      cnt_q       <= cnt_d;
      exmem_mr_q  <= !hold && idex_q.mem_read;
      exmem_mw_q  <= !hold && idex_q.mem_write;
      exmem_rw_q  <= !hold && idex_q.reg_write;
      exmem_m2r_q <= !hold && idex_q.mem_to_reg;
      exmem_dst_q <= hold ? '0 : ex_dst;
      memwb_rw_q  <= exmem_rw_q;
      memwb_m2r_q <= exmem_m2r_q;
      memwb_dst_q <= exmem_dst_q;
    end
  end

`ifdef PIPE_CTRL_FWD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) idex_rs_q <= '0;
    else idex_rs_q <= idex_rs_d;
  end
  assign ctl.fwd_a = (!idex_q.jump && hit(idex_rs_q, exmem_dst_q, exmem_rw_q)) ? FWD_EXMEM :
                     (!idex_q.jump && hit(idex_rs_q, memwb_dst_q, memwb_rw_q)) ? FWD_MEMWB : FWD_RF;
  assign ctl.fwd_b = ((idex_q.reg_dst || idex_q.mem_write || idex_q.branch) && hit(idex_rt_q, exmem_dst_q, exmem_rw_q)) ? FWD_EXMEM :
                     ((idex_q.reg_dst || idex_q.mem_write || idex_q.branch) && hit(idex_rt_q, memwb_dst_q, memwb_rw_q)) ? FWD_MEMWB : FWD_RF;
`endif

  assign ctl.pc_write      = !(hold || (stall && !flush));
  assign ctl.ifid_write    = !(hold || (stall && !flush));
  assign ctl.ifid_flush    = flush;
  assign ctl.ex_alu_src    = idex_q.alu_src;
  assign ctl.ex_branch     = idex_q.branch;
  assign ctl.ex_jump       = idex_q.jump;
  assign ctl.ex_alu_op     = idex_q.alu_op;
  assign ctl.ex_mul_busy   = idex_q.is_mul && hold;
  assign ctl.illegal_op    = idex_q.illegal;
  assign ctl.mem_read      = exmem_mr_q;
  assign ctl.mem_write     = exmem_mw_q;
  assign ctl.wb_reg_write  = memwb_rw_q;
  assign ctl.wb_mem_to_reg = memwb_m2r_q;
  assign ctl.wb_dst        = memwb_dst_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vectors with hand-computed expectations for pipe_ctrl (MUL_CYCLES=4)
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;
  int   wbc;
  int   t_op[9], t_rt[9], t_rd[9];
  logic [4:0] ex_e[9];
  logic [1:0] mem_e[9];
  logic [6:0] wb_e[9];

  pipe_ctrl_if #(.OPCODE_W(6), .REG_ADDR_W(5)) ctl ();
  pipe_ctrl #(.OPCODE_W(6), .REG_ADDR_W(5), .MUL_CYCLES(4)) dut (.clk(clk), .rst(rst), .ctl(ctl));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int op, input int rs, input int rt, input int rd, input logic br);
    ctl.opcode_id   = 6'(op);
    ctl.rs_id       = 5'(rs);
    ctl.rt_id       = 5'(rt);
    ctl.rd_id       = 5'(rd);
    ctl.br_taken_ex = br;
    #1;
  endtask

  task automatic idle();
    drive(OP_BEQ, 0, 0, 0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [18:0] outs();
    return {ctl.pc_write, ctl.ifid_write, ctl.ifid_flush, ctl.ex_alu_src, ctl.ex_branch, ctl.ex_jump,
            ctl.ex_alu_op, ctl.ex_mul_busy, ctl.mem_read, ctl.mem_write, ctl.wb_reg_write,
            ctl.wb_mem_to_reg, ctl.wb_dst, ctl.illegal_op};
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout sim did not finish");
    $fatal(1);
  end

  initial begin
    t_op  = '{OP_R_FORMAT, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_J, OP_BEQ, OP_BEQ, OP_BEQ};
    t_rt  = '{0, 4, 6, 7, 0, 0, 0, 0, 0};
    t_rd  = '{3, 0, 0, 0, 0, 0, 0, 0, 0};
    ex_e  = '{5'b00010, 5'b10000, 5'b10000, 5'b10000, 5'b01001, 5'b00100, 5'b01001, 5'b01001, 5'b01001};
    mem_e = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    wb_e  = '{7'b1000011, 7'b1000100, 7'b1100110, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
    idle();
    repeat (2) step();
    chk("reset_outs", 32'(outs()), {13'd0, 2'b11, 17'd0});
    rst = 1'b0;
    // independent instructions, one per cycle: check EX at +1, MEM at +2, WB at +3
    for (int k = 0; k < 9; k++) begin
      drive(t_op[k], 0, t_rt[k], t_rd[k], 1'b0);
      chk("tbl_pc", 32'(ctl.pc_write), 1);
      if (k >= 1) chk("tbl_ex", 32'({ctl.ex_alu_src, ctl.ex_branch, ctl.ex_jump, ctl.ex_alu_op}), 32'(ex_e[k-1]));
      if (k >= 2) chk("tbl_mem", 32'({ctl.mem_read, ctl.mem_write}), 32'(mem_e[k-2]));
      if (k >= 3) chk("tbl_wb", 32'({ctl.wb_reg_write, ctl.wb_mem_to_reg, ctl.wb_dst}), 32'(wb_e[k-3]));
      step();
    end
    // LW $2,0($1) then ADD $3,$2,$4
    drive(OP_LW, 1, 2, 0, 1'b0);
    chk("lu_issue_pc", 32'(ctl.pc_write), 1);
    step();
    drive(OP_R_FORMAT, 2, 4, 3, 1'b0);
    chk("lu_stall1_pc", 32'(ctl.pc_write), 0);
    chk("lu_stall1_ifid", 32'(ctl.ifid_write), 0);
    step();
    chk("lu_lw_mem", 32'(ctl.mem_read), 1);
`ifdef PIPE_CTRL_FWD_EN
    chk("lu_fwd_go_pc", 32'(ctl.pc_write), 1);
    step();
    idle();
    chk("lu_fwd_a", 32'(ctl.fwd_a), 1);
    chk("lu_fwd_b", 32'(ctl.fwd_b), 0);
    chk("lu_wb_dst", 32'(ctl.wb_dst), 2);
    step();
`else
    chk("lu_stall2_pc", 32'(ctl.pc_write), 0);
    step();
    chk("lu_go_pc", 32'(ctl.pc_write), 1);
    chk("lu_wb_dst", 32'(ctl.wb_dst), 2);
    chk("lu_wb_m2r", 32'(ctl.wb_mem_to_reg), 1);
    step();
    idle();
    chk("lu_add_ex", 32'(ctl.ex_alu_op), 2);
    step();
`endif
    // ADD $2,$0,$0 then SUB $5,$2,$2
    drive(OP_R_FORMAT, 0, 0, 2, 1'b0);
    step();
    drive(OP_R_FORMAT, 2, 2, 5, 1'b0);
`ifdef PIPE_CTRL_FWD_EN
    chk("as_nostall_pc", 32'(ctl.pc_write), 1);
    step();
    idle();
    chk("as_fwd_a", 32'(ctl.fwd_a), 2);
    chk("as_fwd_b", 32'(ctl.fwd_b), 2);
`else
    chk("as_stall1_pc", 32'(ctl.pc_write), 0);
    step();
    chk("as_stall2_pc", 32'(ctl.pc_write), 0);
    step();
    chk("as_go_pc", 32'(ctl.pc_write), 1);
    step();
    idle();
`endif
    repeat (3) step();
    // taken BEQ in EX while a LW dependent on the ADDIU in MEM sits in ID
    drive(OP_ADDIU, 0, 2, 0, 1'b0);
    step();
    idle();
    step();
    drive(OP_LW, 2, 9, 0, 1'b1);
    chk("fl_flush", 32'(ctl.ifid_flush), 1);
    chk("fl_pc", 32'(ctl.pc_write), 1);
    chk("fl_ifid", 32'(ctl.ifid_write), 1);
    chk("fl_ex_branch", 32'(ctl.ex_branch), 1);
    step();
    idle();
    chk("fl_ex_nop", 32'({ctl.ex_alu_src, ctl.ex_branch, ctl.ex_jump, ctl.ex_alu_op}), 0);
    chk("fl_flush_off", 32'(ctl.ifid_flush), 0);
    repeat (3) step();
    // MADDU $10,$6,$7 holds EX for three extra cycles
    drive(OP_MADDU, 6, 7, 10, 1'b0);
    chk("mul_issue_pc", 32'(ctl.pc_write), 1);
    step();
    idle();
    wbc = 0;
    for (int i = 0; i < 3; i++) begin
      chk("mul_busy", 32'(ctl.ex_mul_busy), 1);
      chk("mul_pc_hold", 32'(ctl.pc_write), 0);
      if (ctl.wb_reg_write && ctl.wb_dst == 5'd10) wbc++;
      step();
    end
    chk("mul_busy_end", 32'(ctl.ex_mul_busy), 0);
    chk("mul_pc_rel", 32'(ctl.pc_write), 1);
    chk("mul_ex_op", 32'(ctl.ex_alu_op), 2);
    for (int i = 0; i < 5; i++) begin
      if (ctl.wb_reg_write && ctl.wb_dst == 5'd10) wbc++;
      step();
    end
    chk("mul_wb_once", 32'(wbc), 1);
    // reset in the middle of a MADDU hold
    drive(OP_MADDU, 6, 7, 10, 1'b0);
    step();
    chk("rst_pre_busy", 32'(ctl.ex_mul_busy), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_outs", 32'(outs()), {13'd0, 2'b11, 17'd0});
    idle();
    step();
    rst = 1'b0;
    drive(OP_LW, 0, 11, 0, 1'b0);
    chk("rst_rel_busy", 32'(ctl.ex_mul_busy), 0);
    chk("rst_rel_pc", 32'(ctl.pc_write), 1);
    step();
    idle();
    chk("rst_lw_mem_early", 32'(ctl.mem_read), 0);
    step();
    chk("rst_lw_mem", 32'(ctl.mem_read), 1);
    step();
    chk("rst_lw_mem_late", 32'(ctl.mem_read), 0);
    repeat (2) step();
    // unimplemented opcode 63
    drive(63, 0, 0, 0, 1'b0);
    step();
    idle();
    chk("ill_pulse", 32'(ctl.illegal_op), 1);
    step();
    chk("ill_pulse_end", 32'(ctl.illegal_op), 0);
    chk("ill_mem", 32'({ctl.mem_read, ctl.mem_write}), 0);
    step();
    chk("ill_wb", 32'(ctl.wb_reg_write), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
